// File: rtl/bus_periph_pkg.sv
// Shared register map, CTRL bit positions and FSM encodings for the bus-attached
// timer peripherals.
package bus_periph_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } timer_state_e;

  localparam logic [1:0] OFF_CTRL   = 2'd0;
  localparam logic [1:0] OFF_LOAD   = 2'd1;
  localparam logic [1:0] OFF_COUNT  = 2'd2;
  localparam logic [1:0] OFF_STATUS = 2'd3;

  localparam int unsigned CTRL_EN_BIT     = 0;
  localparam int unsigned CTRL_AUTO_BIT   = 1;
  localparam int unsigned CTRL_IRQ_EN_BIT = 2;
  localparam int unsigned CTRL_PRESC_LSB  = 16;

  localparam int unsigned STATUS_EXP_BIT  = 0;

endpackage

// File: rtl/timer_prescaler.sv
// Free-running prescaler: counts while run is high and pulses tick on the cycle
// the count equals presc, giving a tick period of presc+1 cycles.
module timer_prescaler
  import bus_periph_pkg::*;
#(
  parameter int unsigned PRESC_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               run,
  input  logic               clear,
  input  logic [PRESC_W-1:0] presc,
  output logic               tick
);

  logic [PRESC_W-1:0] cnt;

  assign tick = run && (cnt == presc);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (run) begin
      cnt <= tick ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/bus_timer_responder.sv
// Memory-mapped down-counting timer on the CPU's internal-memory bus: CTRL, LOAD,
// COUNT and STATUS registers, one-shot or auto-reload, with a level interrupt.
module bus_timer_responder
  import bus_periph_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_2000,
  parameter int unsigned PRESC_W   = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] ADDR,
  input  logic [31:0] DATA_BUS_WRITE,
  input  logic        we,
  input  logic        cs,
  output logic [31:0] DATA_BUS_READ,
  output logic        irq
);

  timer_state_e state, state_nxt;

  logic               ctrl_auto;
  logic               ctrl_irq_en;
  logic [PRESC_W-1:0] ctrl_presc;
  logic [31:0]        load_reg;
  logic [31:0]        count_reg;
  logic               exp_flag;

  logic        sel;
  logic [1:0]  reg_off;
  logic        wr_ctrl, wr_load, wr_status, wr_en;
  logic        running, start, stop, presc_run;
  logic        tick, expire;
  logic [31:0] ctrl_word, rd_word;
  logic        unused_addr_bits;

  assign sel       = !cs && (ADDR[31:4] == BASE_ADDR[31:4]);
  assign reg_off   = ADDR[3:2];
  assign wr_ctrl   = sel && we && (reg_off == OFF_CTRL);
  assign wr_load   = sel && we && (reg_off == OFF_LOAD);
  assign wr_status = sel && we && (reg_off == OFF_STATUS);
  assign wr_en     = DATA_BUS_WRITE[CTRL_EN_BIT];
  assign expire    = tick && (count_reg == '0);
  assign unused_addr_bits = ^ADDR[1:0];

  timer_prescaler #(
    .PRESC_W(PRESC_W)
  ) u_presc (
    .clk  (clk),
    .rst_n(rst),
    .run  (presc_run),
    .clear(start),
    .presc(ctrl_presc),
    .tick (tick)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE, ST_DONE: if (wr_ctrl && wr_en) state_nxt = ST_RUN;
      ST_RUN: begin
        if (wr_ctrl && !wr_en)        state_nxt = ST_IDLE;
        else if (expire && !ctrl_auto) state_nxt = ST_DONE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // A disabling CTRL write wins over a coincident tick so COUNT and the
  // prescaler freeze exactly where they were.
  always_comb begin
    running   = (state == ST_RUN);
    start     = !running && wr_ctrl && wr_en;
    stop      = running && wr_ctrl && !wr_en;
    presc_run = running && !stop;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ctrl_auto   <= 1'b0;
      ctrl_irq_en <= 1'b0;
      ctrl_presc  <= '0;
    end else if (wr_ctrl) begin
      ctrl_auto   <= DATA_BUS_WRITE[CTRL_AUTO_BIT];
      ctrl_irq_en <= DATA_BUS_WRITE[CTRL_IRQ_EN_BIT];
      ctrl_presc  <= DATA_BUS_WRITE[CTRL_PRESC_LSB +: PRESC_W];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)         load_reg <= '0;
    else if (wr_load) load_reg <= DATA_BUS_WRITE;
  end

  // Expiry uses the AUTO value in force before any same-cycle CTRL write.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_reg <= '0;
    end else if (start) begin
      count_reg <= load_reg;
    end else if (tick) begin
      if (count_reg != '0) count_reg <= count_reg - 32'd1;
      else if (ctrl_auto)  count_reg <= load_reg;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                           exp_flag <= 1'b0;
    else if (expire)                                    exp_flag <= 1'b1;
    else if (wr_status && DATA_BUS_WRITE[STATUS_EXP_BIT]) exp_flag <= 1'b0;
  end

  always_comb begin
    ctrl_word                              = '0;
    ctrl_word[CTRL_EN_BIT]                 = running;
    ctrl_word[CTRL_AUTO_BIT]               = ctrl_auto;
    ctrl_word[CTRL_IRQ_EN_BIT]             = ctrl_irq_en;
    ctrl_word[CTRL_PRESC_LSB +: PRESC_W]   = ctrl_presc;
  end

  always_comb begin
    rd_word = '0;
    case (reg_off)
      OFF_CTRL:   rd_word = ctrl_word;
      OFF_LOAD:   rd_word = load_reg;
      OFF_COUNT:  rd_word = count_reg;
      OFF_STATUS: rd_word[STATUS_EXP_BIT] = exp_flag;
      default:    rd_word = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      DATA_BUS_READ <= '0;
      irq           <= 1'b0;
    end else begin
      DATA_BUS_READ <= (sel && !we) ? rd_word : '0;
      irq           <= exp_flag && ctrl_irq_en;
    end
  end

endmodule

// File: tb/tb_bus_timer_responder.sv
// Self-checking bench for bus_timer_responder: behavioural model compared every
// cycle, directed scenarios with literal expectations, then randomized traffic.
module tb_bus_timer_responder;

  localparam logic [31:0] BASE = 32'h0000_2000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] ADDR = '0;
  logic [31:0] DATA_BUS_WRITE = '0;
  logic        we = 1'b0;
  logic        cs = 1'b1;
  logic [31:0] DATA_BUS_READ;
  logic        irq;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  bus_timer_responder #(
    .BASE_ADDR(BASE),
    .PRESC_W  (16)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .ADDR          (ADDR),
    .DATA_BUS_WRITE(DATA_BUS_WRITE),
    .we            (we),
    .cs            (cs),
    .DATA_BUS_READ (DATA_BUS_READ),
    .irq           (irq)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, expv, $time);
    end
  endtask

  // Behavioural model: IDLE and DONE look identical from the bus, so a single
  // "running" flag captures the timer's mode.
  bit          m_run, m_auto, m_irq_en, m_exp, m_irq;
  int unsigned m_presc, m_pcnt;
  logic [31:0] m_load, m_count, m_dbr;

  function automatic logic [31:0] m_reg(input logic [1:0] off);
    logic [31:0] v;
    v = '0;
    case (off)
      2'd0: begin
        v[31:16] = m_presc[15:0];
        v[2] = m_irq_en; v[1] = m_auto; v[0] = m_run;
      end
      2'd1: v = m_load;
      2'd2: v = m_count;
      default: v[0] = m_exp;
    endcase
    return v;
  endfunction

  always @(posedge clk or negedge rst) begin : model
    bit sel, wc, wl, ws, start, stop, tick, expire;
    logic [1:0] off;
    if (!rst) begin
      m_run = 0; m_auto = 0; m_irq_en = 0; m_exp = 0; m_irq = 0;
      m_presc = 0; m_pcnt = 0; m_load = '0; m_count = '0; m_dbr = '0;
    end else begin
      sel    = !cs && (ADDR[31:4] == BASE[31:4]);
      off    = ADDR[3:2];
      wc     = sel && we && off == 2'd0;
      wl     = sel && we && off == 2'd1;
      ws     = sel && we && off == 2'd3;
      m_dbr  = (sel && !we) ? m_reg(off) : 32'd0;
      m_irq  = m_exp && m_irq_en;
      start  = !m_run && wc && DATA_BUS_WRITE[0];
      stop   = m_run && wc && !DATA_BUS_WRITE[0];
      tick   = m_run && !stop && (m_pcnt == m_presc);
      expire = tick && (m_count == 0);
      if (start) begin
        m_count = m_load; m_pcnt = 0; m_run = 1;
      end else if (m_run && !stop) begin
        m_pcnt = tick ? 0 : (m_pcnt + 1) % 65536;
        if (tick) begin
          if (m_count != 0) m_count = m_count - 1;
          else if (m_auto)  m_count = m_load;
          else              m_run = 0;
        end
      end
      if (stop) m_run = 0;
      if (expire) m_exp = 1;
      else if (ws && DATA_BUS_WRITE[0]) m_exp = 0;
      if (wc) begin
        m_auto   = DATA_BUS_WRITE[1];
        m_irq_en = DATA_BUS_WRITE[2];
        m_presc  = int'(DATA_BUS_WRITE[31:16]);
      end
      if (wl) m_load = DATA_BUS_WRITE;
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      check("model_dbr", DATA_BUS_READ, m_dbr);
      check("model_irq", {31'd0, irq}, {31'd0, m_irq});
    end
  end

  task automatic access(input bit c, input bit w, input logic [31:0] a, input logic [31:0] d);
    cs = c; we = w; ADDR = a; DATA_BUS_WRITE = d;
    @(negedge clk);
    cs = 1'b1; we = 1'b0;
  endtask

  task automatic bus_write(input logic [1:0] off, input logic [31:0] d);
    access(1'b0, 1'b1, BASE | {28'd0, off, 2'b00}, d);
  endtask

  task automatic bus_read(input logic [1:0] off, output logic [31:0] d);
    access(1'b0, 1'b0, BASE | {28'd0, off, 2'b00}, 32'd0);
    d = DATA_BUS_READ;
  endtask

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
    $fatal(1, "timeout");
  end

  initial begin : stim
    logic [31:0] rd;
    bit found;
    #2 rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 4; i++) begin
      bus_read(2'(i), rd);
      check("reset_read", rd, 32'd0);
    end
    check("reset_irq", {31'd0, irq}, 32'd0);

    // One-shot, PRESC=0
    bus_write(2'd1, 32'd3);
    bus_write(2'd0, 32'h0000_0005);
    for (int i = 3; i >= 0; i--) begin
      bus_read(2'd2, rd);
      check("oneshot_count", rd, 32'(i));
    end
    check("oneshot_irq_before", {31'd0, irq}, 32'd0);
    bus_read(2'd3, rd);
    check("oneshot_exp", rd, 32'd1);
    check("oneshot_irq", {31'd0, irq}, 32'd1);
    bus_read(2'd0, rd);
    check("oneshot_ctrl_en0", rd, 32'h0000_0004);
    bus_read(2'd2, rd);
    check("oneshot_count_hold", rd, 32'd0);
    bus_write(2'd3, 32'd1);

    // Auto-reload, PRESC=2
    bus_write(2'd1, 32'd2);
    bus_write(2'd0, 32'h0002_0003);
    repeat (9) @(negedge clk);
    bus_read(2'd2, rd);
    check("auto_reload_count", rd, 32'd2);
    bus_read(2'd3, rd);
    check("auto_exp", rd, 32'd1);
    bus_read(2'd0, rd);
    check("auto_ctrl_run", rd, 32'h0002_0003);

    // STATUS clear coinciding with expiry
    bus_write(2'd0, 32'h0002_0007);
    bus_write(2'd3, 32'd1);
    bus_read(2'd3, rd);
    check("status_cleared", rd, 32'd0);
    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      if (m_run && m_pcnt == m_presc && m_count == 0) begin
        bus_write(2'd3, 32'd1);
        found = 1;
      end else begin
        @(negedge clk);
      end
    end
    check("expiry_found", {31'd0, found}, 32'd1);
    bus_read(2'd3, rd);
    check("set_wins_exp", rd, 32'd1);
    check("set_wins_irq", {31'd0, irq}, 32'd1);
    bus_write(2'd3, 32'd1);
    @(negedge clk);
    check("clear_irq", {31'd0, irq}, 32'd0);
    bus_read(2'd3, rd);
    check("clear_exp", rd, 32'd0);

    // Deselected / out-of-window accesses
    access(1'b1, 1'b1, BASE + 32'h4, 32'hDEAD_BEEF);
    access(1'b0, 1'b1, BASE + 32'h14, 32'hCAFE_F00D);
    access(1'b1, 1'b0, BASE + 32'h4, 32'd0);
    check("cs_high_read", DATA_BUS_READ, 32'd0);
    access(1'b0, 1'b0, BASE + 32'h14, 32'd0);
    check("out_of_window_read", DATA_BUS_READ, 32'd0);
    bus_read(2'd1, rd);
    check("load_unchanged", rd, 32'd2);

    // Asynchronous reset mid-count
    bus_write(2'd0, 32'd0);
    bus_write(2'd1, 32'd100);
    bus_write(2'd0, 32'd1);
    cs = 1'b0; we = 1'b0; ADDR = BASE + 32'h8;
    repeat (5) @(negedge clk);
    check("pre_reset_count_nonzero", {31'd0, DATA_BUS_READ != 0}, 32'd1);
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    check("async_reset_dbr", DATA_BUS_READ, 32'd0);
    check("async_reset_irq", {31'd0, irq}, 32'd0);
    cs = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    bus_read(2'd2, rd);
    check("post_reset_count", rd, 32'd0);
    bus_read(2'd0, rd);
    check("post_reset_ctrl", rd, 32'd0);

    // Randomized traffic checked by the model
    repeat (3000) begin
      int unsigned r;
      logic [1:0]  off;
      logic [31:0] a, d;
      bit c, w;
      r   = $urandom_range(0, 9);
      off = 2'($urandom_range(0, 3));
      a   = BASE | {28'd0, off, 2'($urandom_range(0, 3))};
      c   = (r == 0);
      if (r == 1) a = a + 32'h10;
      w   = ($urandom_range(0, 1) == 1);
      d   = $urandom;
      if (off == 2'd0) begin
        d[31:16] = 16'($urandom_range(0, 3));
        d[0]     = ($urandom_range(0, 3) != 0);
      end else if (off == 2'd1) begin
        d = 32'($urandom_range(0, 6));
      end
      access(c, w, a, d);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
